// File: rtl/demux_1_n_reg.sv
// 1-to-N registered demux with a one-entry holding register per channel; DEMUX_SEL_ERR_EN adds sel_err/sel_err_cnt.
// Latency: one cycle from upstream accept to out_valid.
// Backpressure: in_ready follows only the selected channel, so a stalled channel never blocks the others.
module demux_1_n_reg #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
`ifdef DEMUX_SEL_ERR_EN
  output logic [7:0]         sel_err_cnt,
  output logic               sel_err,
`endif
  output logic [N*WIDTH-1:0] out_data
);

  logic [N-1:0]     valid_q, valid_d;
  logic [WIDTH-1:0] data_q [N];
  logic [WIDTH-1:0] data_d [N];
  logic             sel_ok;
  logic             chan_rdy;

  // Widen by one bit so N=2^SEL_W still compares correctly.
  assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(N));

  // Out-of-range selects match no channel, so they are always accepted and dropped.
  always_comb begin
    chan_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel_ok && (in_sel == SEL_W'(k))) begin
        chan_rdy = !valid_q[k] || out_ready[k];
      end
    end
  end

  assign in_ready = chan_rdy;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < N; k++) begin
      data_d[k] = data_q[k];
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
      if (in_valid && in_ready && sel_ok && (in_sel == SEL_W'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = valid_q;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

`ifdef DEMUX_SEL_ERR_EN
  logic       sel_err_q, sel_err_d;
  logic [7:0] sel_err_cnt_q, sel_err_cnt_d;

  always_comb begin
    sel_err_d     = in_valid && !sel_ok;
    sel_err_cnt_d = sel_err_cnt_q;
    if (sel_err_d && (sel_err_cnt_q != 8'hFF)) begin
      sel_err_cnt_d = sel_err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q     <= 1'b0;
      sel_err_cnt_q <= 8'd0;
    end else begin
      sel_err_q     <= sel_err_d;
      sel_err_cnt_q <= sel_err_cnt_d;
    end
  end

  assign sel_err     = sel_err_q;
  assign sel_err_cnt = sel_err_cnt_q;
`endif

endmodule

// File: doc/demux_1_n_reg.md
DEMUX_1_N_REG -- requirements
Module: demux_1_n_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits per channel; SHALL be legal for 1..64.
REQ-002 Parameter N, default 4, output channel count; SHALL be legal for 2..16.
REQ-003 Localparam SEL_W = max(1, clog2(N)) SHALL size the select field.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept the upstream word this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 in_sel  input  SEL_W  destination channel, sampled with in_data.
REQ-010 out_valid  output  N  per-channel word present; bit k is channel k.
REQ-011 out_ready  input  N  per-channel downstream accept.
REQ-012 out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].

Function
REQ-013 Each channel SHALL own a one-entry holding register (data plus valid flag).
REQ-014 Upstream transfer SHALL occur when in_valid && in_ready at a rising edge.
REQ-015 in_ready SHALL be combinational: 1 when in_sel >= N; otherwise 1 when !out_valid[in_sel] || out_ready[in_sel].
REQ-016 On transfer with in_sel < N, channel in_sel SHALL load in_data and set out_valid[in_sel] at that edge, giving one cycle of latency.
REQ-017 Downstream transfer on channel k SHALL occur when out_valid[k] && out_ready[k]; without a simultaneous load, out_valid[k] SHALL clear at that edge.
REQ-018 Simultaneous downstream transfer and upstream load on the same channel SHALL leave out_valid[k]=1 with the new word, so one word per cycle per channel is sustained.
REQ-019 out_data for channel k SHALL hold stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 Channels SHALL be independent: a stalled channel SHALL NOT block an upstream word destined for another channel.
REQ-021 A transfer with in_sel >= N (possible only when N is not a power of two) SHALL be consumed and discarded, with no channel state change.
REQ-022 in_data and in_sel SHALL be ignored when in_valid=0.
REQ-023 out_data of an empty channel is don't-care but SHALL be deterministic: it retains the last loaded word.

Reset
REQ-024 rst_n=0 SHALL immediately clear all out_valid bits to 0 and out_data to 0, regardless of clk.
REQ-025 Words held at reset assertion SHALL be lost; no transfer SHALL complete while rst_n=0.
REQ-026 Reset release SHALL be synchronised externally; the first transfer is legal on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro DEMUX_SEL_ERR_EN defined SHALL add output port sel_err_cnt, 8 bits wide: a saturating count of REQ-021 discards, reset to 0, holding at 255.
REQ-028 Macro DEMUX_SEL_ERR_EN defined SHALL also add output port sel_err, 1 bit wide, pulsed for one cycle after each discard.
REQ-029 Macro DEMUX_SEL_ERR_EN undefined SHALL remove sel_err_cnt and sel_err and their logic; REQ-021 discard behaviour is unchanged.

Verification
REQ-030 N=4, WIDTH=8, out_ready=4'hF; send 0xA5 sel=2 -> next cycle out_valid=4'b0100, channel 2 data 0xA5, cleared the cycle after.
REQ-031 out_ready[1]=0; send 0x11 then 0x22 to sel=1 -> second word stalls (in_ready=0) with channel 1 holding 0x11; release out_ready[1] -> 0x22 loads in the same edge 0x11 leaves.
REQ-032 Channel 0 stalled and full; send 0x33 sel=3 -> accepted immediately and out_valid[3]=1 next cycle; channel 0 unchanged.
REQ-033 Back-to-back stream of 16 words rotating sel 0..3 with all out_ready=1 -> in_ready constantly 1, every word appears once in order per channel, no loss.
REQ-034 N=5, macro defined; send 300 words with sel=7 -> all accepted, no out_valid asserted, sel_err pulses 300 times, sel_err_cnt=255.
REQ-035 Assert rst_n=0 mid-cycle with channels 0 and 2 full -> out_valid=0 and out_data=0 before the next clk edge; post-release traffic is correct.
